fpaddsub_scheduler: RTL

Shares one fixed-latency single-precision FP add/sub pipeline between two requesters. Round-robin arbitration admits at most one operation per cycle. The block tracks each issued operation's owner through the pipeline latency and routes the result and its 5-bit exception flags back to that owner. It also keeps one sticky IEEE status register per requester. It sits between the requester ports and the add/sub datapath plus its exception stage.

---
 rtl/fpaddsub_pkg.sv | 56 +++++
 rtl/fpaddsub_scheduler_if.sv | 78 +++++++
 rtl/fpaddsub_tag_pipe.sv | 55 +++++
 rtl/fpaddsub_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fpaddsub_pkg.sv
// ============================================================================
// Package  : fpaddsub_pkg
// Purpose  : Shared widths, flag bit positions, opcodes, requester ids and
//            the sticky-status update rule for the FP add/sub scheduler.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpaddsub_pkg;

    // Operand / flag widths
    localparam int FP_W   = 32;
    localparam int FLAG_W = 5;

    // Exception flag bit positions inside a FLAG_W vector
    localparam int FLG_OF  = 4;   // overflow
    localparam int FLG_UF  = 3;   // underflow
    localparam int FLG_DZ  = 2;   // divide by zero
    localparam int FLG_INV = 1;   // invalid
    localparam int FLG_NX  = 0;   // inexact

    // Operation encoding on req*_op / dp_op
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Requester identifier carried through the tag pipeline
    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    typedef logic [FP_W-1:0]   fp_t;
    typedef logic [FLAG_W-1:0] flags_t;

    // Next value of a sticky status register.
    // A clear that coincides with a response keeps only the new flags, so
    // the event that arrives together with the clear is never lost.
    function automatic flags_t sticky_next(
        input flags_t cur,
        input flags_t flags,
        input logic   hit,
        input logic   clr
    );
        flags_t nxt;
        if (hit) begin
            nxt = clr ? flags : (cur | flags);
        end else begin
            nxt = clr ? '0 : cur;
        end
        return nxt;
    endfunction

endpackage : fpaddsub_pkg

`default_nettype wire

// File: rtl/fpaddsub_scheduler_if.sv
// ============================================================================
// Interface : fpaddsub_scheduler_if
// Purpose   : Bundles the requester ports, the datapath issue/return bus,
//             the per-requester response ports, sticky status/clear and busy
//             of the FP add/sub scheduler.
// Modports  : slave  - scheduler side (drives ready, dp_*, rsp*, sticky*, busy)
//             master - environment side (requesters, datapath, clear strobes)
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fpaddsub_scheduler_if;
    import fpaddsub_pkg::*;

    // Requester 0
    logic              req0_valid;
    logic              req0_ready;
    logic [FP_W-1:0]   req0_a;
    logic [FP_W-1:0]   req0_b;
    logic              req0_op;

    // Requester 1
    logic              req1_valid;
    logic              req1_ready;
    logic [FP_W-1:0]   req1_a;
    logic [FP_W-1:0]   req1_b;
    logic              req1_op;

    // Shared datapath
    logic              dp_valid;
    logic [FP_W-1:0]   dp_a;
    logic [FP_W-1:0]   dp_b;
    logic              dp_op;
    logic [FP_W-1:0]   dp_result;
    logic [FLAG_W-1:0] dp_flags;

    // Responses
    logic              rsp0_valid;
    logic [FP_W-1:0]   rsp0_data;
    logic [FLAG_W-1:0] rsp0_flags;
    logic              rsp1_valid;
    logic [FP_W-1:0]   rsp1_data;
    logic [FLAG_W-1:0] rsp1_flags;

    // Status
    logic [FLAG_W-1:0] sticky0;
    logic [FLAG_W-1:0] sticky1;
    logic              clr0;
    logic              clr1;
    logic              busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  dp_result, dp_flags,
        input  clr0, clr1,
        output req0_ready, req1_ready,
        output dp_valid, dp_a, dp_b, dp_op,
        output rsp0_valid, rsp0_data, rsp0_flags,
        output rsp1_valid, rsp1_data, rsp1_flags,
        output sticky0, sticky1, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output dp_result, dp_flags,
        output clr0, clr1,
        input  req0_ready, req1_ready,
        input  dp_valid, dp_a, dp_b, dp_op,
        input  rsp0_valid, rsp0_data, rsp0_flags,
        input  rsp1_valid, rsp1_data, rsp1_flags,
        input  sticky0, sticky1, busy
    );

endinterface : fpaddsub_scheduler_if

`default_nettype wire

// File: rtl/fpaddsub_tag_pipe.sv
// ============================================================================
// Module   : fpaddsub_tag_pipe
// Purpose  : LAT-deep {valid, owner id} shift register that follows each
//            issued operation through the fixed datapath latency. Its tail
//            lines up with the datapath result.
// Ports    : clk          - clock
//            rst_n        - asynchronous active-low reset (drops all tags)
//            in_valid_i   - issue strobe entering the pipeline
//            in_id_i      - owner of the issued operation
//            tail_valid_o - an operation's result is on the datapath now
//            tail_id_o    - owner of that result
//            any_valid_o  - at least one tag is in flight
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpaddsub_tag_pipe
    import fpaddsub_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    in_valid_i,
    input  req_id_t in_id_i,
    output logic    tail_valid_o,
    output req_id_t tail_id_o,
    output logic    any_valid_o
);

    logic [LAT-1:0] vld_q;
    logic [LAT-1:0] id_q;

    // Free-running shift: the datapath never stalls, so neither do the tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q[0] <= in_valid_i;
            id_q[0]  <= in_id_i;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                id_q[i]  <= id_q[i-1];
            end
        end
    end

    assign tail_valid_o = vld_q[LAT-1];
    assign tail_id_o    = req_id_t'(id_q[LAT-1]);
    assign any_valid_o  = |vld_q;

endmodule : fpaddsub_tag_pipe

`default_nettype wire

// File: rtl/fpaddsub_scheduler.sv
// ============================================================================
// Module   : fpaddsub_scheduler
// Purpose  : Shares one fixed-latency FP add/sub datapath between two
//            requesters. Round-robin arbitration admits one operation per
//            cycle; an owner tag follows each operation through the datapath
//            latency so the result and flags return to the right requester.
//            A sticky IEEE status register is kept per requester.
// Ports    : clk   - clock, all state on the rising edge
//            rst_n - asynchronous active-low reset
//            bus   - scheduler side of fpaddsub_scheduler_if:
//                    req0/1 valid/ready/a/b/op, dp_valid/a/b/op,
//                    dp_result/flags, rsp0/1 valid/data/flags,
//                    sticky0/1, clr0/1, busy
// Timing   : handshake h -> dp_valid h+1 -> dp_result h+1+LAT ->
//            rsp strobe and sticky update h+2+LAT
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpaddsub_scheduler
    import fpaddsub_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fpaddsub_scheduler_if.slave   bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    req_id_t ptr_q,        ptr_d;
    logic    dp_valid_q,   dp_valid_d;
    fp_t     dp_a_q,       dp_a_d;
    fp_t     dp_b_q,       dp_b_d;
    logic    dp_op_q,      dp_op_d;
    req_id_t owner_q,      owner_d;

    logic    rsp0_valid_q, rsp0_valid_d;
    fp_t     rsp0_data_q,  rsp0_data_d;
    flags_t  rsp0_flags_q, rsp0_flags_d;
    logic    rsp1_valid_q, rsp1_valid_d;
    fp_t     rsp1_data_q,  rsp1_data_d;
    flags_t  rsp1_flags_q, rsp1_flags_d;

    flags_t  sticky0_q,    sticky0_d;
    flags_t  sticky1_q,    sticky1_d;

    // ------------------------------------------------------------------
    // Combinational wires
    // ------------------------------------------------------------------
    logic    w_grant0;
    logic    w_grant1;
    logic    w_tail_valid;
    req_id_t w_tail_id;
    logic    w_any_valid;
    logic    w_hit0;
    logic    w_hit1;

    // ------------------------------------------------------------------
    // Arbitration
    // A lone requester always wins; on contention ptr decides. Grants are
    // qualified by valid so at most one ready is ever high, and masked
    // during reset so no handshake can complete while state is held clear.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant0 = rst_n & bus.req0_valid & (~bus.req1_valid | (ptr_q == REQ0));
        w_grant1 = rst_n & bus.req1_valid & (~bus.req0_valid | (ptr_q == REQ1));
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;

    // ------------------------------------------------------------------
    // Pointer and issue registers: next state
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d      = ptr_q;
        dp_valid_d = 1'b0;
        dp_a_d     = dp_a_q;
        dp_b_d     = dp_b_q;
        dp_op_d    = dp_op_q;
        owner_d    = owner_q;

        if (w_grant0) begin
            ptr_d      = REQ1;
            dp_valid_d = 1'b1;
            dp_a_d     = bus.req0_a;
            dp_b_d     = bus.req0_b;
            dp_op_d    = bus.req0_op;
            owner_d    = REQ0;
        end else if (w_grant1) begin
            ptr_d      = REQ0;
            dp_valid_d = 1'b1;
            dp_a_d     = bus.req1_a;
            dp_b_d     = bus.req1_b;
            dp_op_d    = bus.req1_op;
            owner_d    = REQ1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= REQ0;
            dp_valid_q <= 1'b0;
            dp_a_q     <= '0;
            dp_b_q     <= '0;
            dp_op_q    <= OP_ADD;
            owner_q    <= REQ0;
        end else begin
            ptr_q      <= ptr_d;
            dp_valid_q <= dp_valid_d;
            dp_a_q     <= dp_a_d;
            dp_b_q     <= dp_b_d;
            dp_op_q    <= dp_op_d;
            owner_q    <= owner_d;
        end
    end

    assign bus.dp_valid = dp_valid_q;
    assign bus.dp_a     = dp_a_q;
    assign bus.dp_b     = dp_b_q;
    assign bus.dp_op    = dp_op_q;

    // ------------------------------------------------------------------
    // Owner tracking: loaded from the registered issue strobe so the tail
    // coincides with the cycle dp_result belongs to that issue.
    // ------------------------------------------------------------------
    fpaddsub_tag_pipe #(
        .LAT (LAT)
    ) u_tag_pipe (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (dp_valid_q),
        .in_id_i      (owner_q),
        .tail_valid_o (w_tail_valid),
        .tail_id_o    (w_tail_id),
        .any_valid_o  (w_any_valid)
    );

    // ------------------------------------------------------------------
    // Response routing and sticky status: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_hit0 = w_tail_valid & (w_tail_id == REQ0);
        w_hit1 = w_tail_valid & (w_tail_id == REQ1);

        rsp0_valid_d = w_hit0;
        rsp0_data_d  = rsp0_data_q;
        rsp0_flags_d = rsp0_flags_q;
        rsp1_valid_d = w_hit1;
        rsp1_data_d  = rsp1_data_q;
        rsp1_flags_d = rsp1_flags_q;

        if (w_hit0) begin
            rsp0_data_d  = bus.dp_result;
            rsp0_flags_d = bus.dp_flags;
        end
        if (w_hit1) begin
            rsp1_data_d  = bus.dp_result;
            rsp1_flags_d = bus.dp_flags;
        end

        sticky0_d = sticky_next(sticky0_q, bus.dp_flags, w_hit0, bus.clr0);
        sticky1_d = sticky_next(sticky1_q, bus.dp_flags, w_hit1, bus.clr1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp0_flags_q <= '0;
            rsp1_valid_q <= 1'b0;
            rsp1_data_q  <= '0;
            rsp1_flags_q <= '0;
            sticky0_q    <= '0;
            sticky1_q    <= '0;
        end else begin
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp0_flags_q <= rsp0_flags_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_data_q  <= rsp1_data_d;
            rsp1_flags_q <= rsp1_flags_d;
            sticky0_q    <= sticky0_d;
            sticky1_q    <= sticky1_d;
        end
    end

    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp0_data  = rsp0_data_q;
    assign bus.rsp0_flags = rsp0_flags_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp1_data  = rsp1_data_q;
    assign bus.rsp1_flags = rsp1_flags_q;
    assign bus.sticky0    = sticky0_q;
    assign bus.sticky1    = sticky1_q;

    // An operation counts as in flight from its dp_valid cycle up to and
    // including its response strobe cycle.
    assign bus.busy = dp_valid_q | w_any_valid | rsp0_valid_q | rsp1_valid_q;

endmodule : fpaddsub_scheduler

`default_nettype wire
